// File: rtl/clk_div_multi.sv
// N-channel programmable clock/tick generator with per-channel period and high-time,
// shadowed configuration applied at period start, global enable and sync restart.
module clk_div_multi #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned DEF_DIV = 49999,
  parameter int unsigned DEF_HI  = 25000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]  div_val,
  input  logic [CNT_W-1:0]  hi_val,
  output logic [N_CH-1:0]   cfg_pend,
  output logic [N_CH-1:0]   clk_div,
  output logic [N_CH-1:0]   tick
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_HI_V  = CNT_W'(DEF_HI);

  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] per_r  [N_CH];
  logic [CNT_W-1:0] hi_r   [N_CH];
  logic [CNT_W-1:0] per_s  [N_CH];
  logic [CNT_W-1:0] hi_s   [N_CH];

  logic [CNT_W-1:0] cnt_nx [N_CH];
  logic [CNT_W-1:0] per_nx [N_CH];
  logic [CNT_W-1:0] hi_nx  [N_CH];
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  wrap;

  // Next-state per channel; parking holds cnt at per_r so the first enabled edge wraps.
  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      wr_hit[ch] = cfg_wr && (ch_sel == CH_W'(ch));
      wrap[ch]   = en && (sync_rst || (cnt[ch] == per_r[ch]));
      per_nx[ch] = per_r[ch];
      hi_nx[ch]  = hi_r[ch];
      cnt_nx[ch] = per_r[ch];
      if (en) begin
        if (wrap[ch]) begin
          cnt_nx[ch] = '0;
          if (wr_hit[ch]) begin
            per_nx[ch] = div_val;
            hi_nx[ch]  = hi_val;
          end else if (cfg_pend[ch]) begin
            per_nx[ch] = per_s[ch];
            hi_nx[ch]  = hi_s[ch];
          end
        end else begin
          cnt_nx[ch] = cnt[ch] + CNT_W'(1);
        end
      end
    end
  end

  // Registered counters, active/shadow config and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        cnt[ch]   <= DEF_DIV_V;
        per_r[ch] <= DEF_DIV_V;
        hi_r[ch]  <= DEF_HI_V;
        per_s[ch] <= DEF_DIV_V;
        hi_s[ch]  <= DEF_HI_V;
      end
      cfg_pend <= '0;
      clk_div  <= '0;
      tick     <= '0;
    end else begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        cnt[ch]   <= cnt_nx[ch];
        per_r[ch] <= per_nx[ch];
        hi_r[ch]  <= hi_nx[ch];
        tick[ch]  <= wrap[ch];
        clk_div[ch] <= en && (cnt_nx[ch] < hi_nx[ch]);
        if (wr_hit[ch]) begin
          per_s[ch] <= div_val;
          hi_s[ch]  <= hi_val;
        end
        // A write landing on a wrap bypasses the shadow, so nothing is left pending.
        if (wrap[ch]) begin
          cfg_pend[ch] <= 1'b0;
        end else if (wr_hit[ch]) begin
          cfg_pend[ch] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: period/phase model checked every cycle plus directed literal checks.
module tb_clk_div_multi;

  localparam int unsigned N_CH    = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned DEF_DIV = 11;
  localparam int unsigned DEF_HI  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              sync_rst = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   ch_sel = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic [CNT_W-1:0]  hi_val = '0;
  logic [N_CH-1:0]   cfg_pend;
  logic [N_CH-1:0]   clk_div;
  logic [N_CH-1:0]   tick;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEF_DIV(DEF_DIV), .DEF_HI(DEF_HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_rst(sync_rst), .cfg_wr(cfg_wr),
    .ch_sel(ch_sel), .div_val(div_val), .hi_val(hi_val),
    .cfg_pend(cfg_pend), .clk_div(clk_div), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is either parked or some number of cycles into a period of length per+1.
  int unsigned m_per [N_CH];
  int unsigned m_hi  [N_CH];
  int unsigned m_sper[N_CH];
  int unsigned m_shi [N_CH];
  int unsigned m_phase[N_CH];
  bit          m_run [N_CH];
  bit          m_pend[N_CH];
  bit          m_wr, m_start;
  logic [N_CH-1:0] e_div = '0, e_tick = '0, e_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        m_per[c] = DEF_DIV; m_hi[c] = DEF_HI; m_sper[c] = DEF_DIV; m_shi[c] = DEF_HI;
        m_phase[c] = 0; m_run[c] = 0; m_pend[c] = 0;
      end
      e_div = '0; e_tick = '0; e_pend = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        m_wr = cfg_wr && (int'(ch_sel) == c);
        if (!en) begin
          m_run[c] = 0;
          e_div[c] = 1'b0;
          e_tick[c] = 1'b0;
          if (m_wr) begin m_sper[c] = div_val; m_shi[c] = hi_val; m_pend[c] = 1; end
        end else begin
          m_start = !m_run[c] || sync_rst || (m_phase[c] + 1 == m_per[c] + 1);
          if (m_start) begin
            if (m_wr) begin m_per[c] = div_val; m_hi[c] = hi_val; end
            else if (m_pend[c]) begin m_per[c] = m_sper[c]; m_hi[c] = m_shi[c]; end
            m_pend[c] = 0;
            m_phase[c] = 0;
            m_run[c] = 1;
          end else begin
            m_phase[c] = m_phase[c] + 1;
            if (m_wr) begin m_sper[c] = div_val; m_shi[c] = hi_val; m_pend[c] = 1; end
          end
          e_tick[c] = m_start;
          e_div[c]  = (m_phase[c] < m_hi[c]);
        end
        e_pend[c] = m_pend[c];
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_clk_div", 32'(clk_div), 32'(e_div));
    chk("cmp_tick", 32'(tick), 32'(e_tick));
    chk("cmp_cfg_pend", 32'(cfg_pend), 32'(e_pend));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cfg(input int ch, input int dv, input int hv);
    cfg_wr = 1'b1; ch_sel = CH_W'(ch); div_val = CNT_W'(dv); hi_val = CNT_W'(hv);
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_tick0(input int budget);
    int n = 0;
    while (!tick[0] && n < budget) begin step(1); n++; end
    chk("wait_tick0", 32'(tick[0]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v8, t8;
    logic [9:0] v10, t10;
    int nt, nh;
    logic d0or, d1and, d2and, t2and;

    // Reset state
    step(3);
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_pend", 32'(cfg_pend), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Default config: period 12, high 6
    en = 1'b1;
    step(1);
    chk("def_first_tick", 32'(tick), 32'h7);
    chk("def_first_div", 32'(clk_div), 32'h7);
    nt = 32'(tick[0]); nh = 32'(clk_div[0]);
    for (int i = 1; i < 24; i++) begin
      step(1); nt += 32'(tick[0]); nh += 32'(clk_div[0]);
    end
    chk("def_ticks_24", 32'(nt), 32'd2);
    chk("def_highs_24", 32'(nh), 32'd12);
    en = 1'b0;
    step(1);
    chk("park_div", 32'(clk_div), 32'd0);

    // Test 1: per 3 / hi 2 written while parked
    for (int c = 0; c < 3; c++) write_cfg(c, 3, 2);
    chk("t1_pend", 32'(cfg_pend), 32'h7);
    en = 1'b1;
    v8 = '0; t8 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1); v8 = {v8[6:0], clk_div[0]}; t8 = {t8[6:0], tick[0]};
    end
    chk("t1_div_seq", 32'(v8), 32'hCC);
    chk("t1_tick_seq", 32'(t8), 32'h88);

    // Test 2: switch 9/5 -> 4/1 at period boundary
    en = 1'b0; step(1);
    write_cfg(0, 9, 5);
    en = 1'b1; step(1);
    step(3);
    write_cfg(0, 4, 1);
    chk("t2_pend_set", 32'(cfg_pend[0]), 32'd1);
    wait_tick0(20);
    chk("t2_pend_clr", 32'(cfg_pend[0]), 32'd0);
    v10 = 10'(clk_div[0]); t10 = 10'(tick[0]);
    for (int i = 1; i < 10; i++) begin
      step(1); v10 = {v10[8:0], clk_div[0]}; t10 = {t10[8:0], tick[0]};
    end
    chk("t2_div_seq", 32'(v10), 32'h210);
    chk("t2_tick_seq", 32'(t10), 32'h210);

    // Test 3: hi=0, hi>per, per=0
    en = 1'b0; step(1);
    write_cfg(0, 9, 0);
    write_cfg(1, 9, 20);
    write_cfg(2, 0, 1);
    en = 1'b1;
    d0or = 1'b0; d1and = 1'b1; d2and = 1'b1; t2and = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      d0or |= clk_div[0]; d1and &= clk_div[1]; d2and &= clk_div[2]; t2and &= tick[2];
    end
    chk("t3_hi0_stuck0", 32'(d0or), 32'd0);
    chk("t3_hibig_stuck1", 32'(d1and), 32'd1);
    chk("t3_per0_div", 32'(d2and), 32'd1);
    chk("t3_per0_tick", 32'(t2and), 32'd1);

    // Test 4: sync restart of out-of-phase channels
    en = 1'b0; step(1);
    write_cfg(0, 6, 3);
    write_cfg(1, 10, 5);
    en = 1'b1; step(9);
    sync_rst = 1'b1; step(1); sync_rst = 1'b0;
    chk("t4_sync_tick", 32'(tick[1:0]), 32'h3);
    step(1);
    chk("t4_after_sync", 32'(tick[1:0]), 32'h0);
    step(6);
    chk("t4_ch0_wrap", 32'(tick[1:0]), 32'h1);
    step(4);
    chk("t4_ch1_wrap", 32'(tick[1]), 32'd1);

    // Test 5: park mid-high, re-enable, write on wrap
    en = 1'b0; step(1);
    chk("t5_park_div", 32'(clk_div), 32'd0);
    chk("t5_park_tick", 32'(tick), 32'd0);
    step(3);
    en = 1'b1; step(1);
    chk("t5_reen_tick", 32'(tick), 32'h7);
    chk("t5_reen_div", 32'(clk_div), 32'h7);
    step(6);
    write_cfg(0, 2, 1);
    chk("t5_bypass_pend", 32'(cfg_pend[0]), 32'd0);
    chk("t5_bypass_tick", 32'(tick[0]), 32'd1);
    chk("t5_bypass_div", 32'(clk_div[0]), 32'd1);
    step(1);
    chk("t5_new_hi1", 32'(clk_div[0]), 32'd0);
    step(2);
    chk("t5_new_per3", 32'(tick[0]), 32'd1);

    // Test 6: async reset mid-high, out-of-range write
    chk("t6_pre_high", 32'(clk_div[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_div", 32'(clk_div), 32'd0);
    chk("t6_async_tick", 32'(tick), 32'd0);
    chk("t6_async_pend", 32'(cfg_pend), 32'd0);
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    write_cfg(3, 2, 1);
    chk("t6_bad_sel", 32'(cfg_pend), 32'd0);
    en = 1'b1; step(1);
    chk("t6_def_tick0", 32'(tick), 32'h7);
    step(11);
    chk("t6_def_mid", 32'(tick), 32'h0);
    step(1);
    chk("t6_def_tick1", 32'(tick), 32'h7);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
